mem_result_checker: RTL and testbench

Synthesizable self-check engine for the pipelined RV32IMC core. It watches the fetched instruction stream until the program has finished, which it detects as RUN_LEN consecutive identical instruction words or an optional cycle timeout. It then sweeps a window of data memory through the core's console read port and compares each word against an expected-value memory. Pass/fail counts, the first failing address and the execution cycle count are exposed so FPGA builds can self-grade without a simulator.

---
 rtl/mem_result_checker.sv | 189 ++++++++++++++++++
 tb/tb_mem_result_checker.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_result_checker.sv
// Self-check engine: waits for the fetch stream to settle, then sweeps a memory window against
// an expected image. Define CHECKER_TIMEOUT_EN to add a MAX_CYCLES exit from MONITOR.
module mem_result_checker #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int BASE       = 0,
  parameter int DEPTH      = 100,
  parameter int RUN_LEN    = 10,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       inst,
  output logic [ADDR_W-1:0] con_addr,
  output logic              con_rd,
  input  logic [DATA_W-1:0] con_out,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MONITOR = 2'd1,
    S_SWEEP   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [IDX_W-1:0]  DEPTH_I = IDX_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);

  if (DEPTH < 1 || RUN_LEN < 1 || MAX_CYCLES < 1) begin : g_param_check
    $error("mem_result_checker: DEPTH, RUN_LEN and MAX_CYCLES must be positive");
  end

  state_t              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [31:0]         last_q, last_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    pass_q, pass_d;
  logic [CNT_W-1:0]    fail_q, fail_d;
  logic                ffv_q, ffv_d;
  logic [ADDR_W-1:0]   ffa_q, ffa_d;
  logic                to_q, to_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic                issue;
  logic [ADDR_W-1:0]   addr_now;
  logic                timeout_hit;

  // Both memories answer exactly one cycle after the address; there is no stall, so the
  // compare stage is simply the issue stage delayed by one register.
  assign issue    = (state_q == S_SWEEP) && (idx_q != DEPTH_I);
  assign addr_now = BASE_A + ADDR_W'(idx_q);

`ifdef CHECKER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);
  assign timeout_hit = ((cyc_q + 1'b1) == MAX_CNT);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= S_IDLE;
      run_q      <= '0;
      last_q     <= '0;
      cyc_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      ffv_q      <= 1'b0;
      ffa_q      <= '0;
      to_q       <= 1'b0;
      idx_q      <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      last_q     <= last_d;
      cyc_q      <= cyc_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ffv_q      <= ffv_d;
      ffa_q      <= ffa_d;
      to_q       <= to_d;
      idx_q      <= idx_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    last_d     = last_q;
    cyc_d      = cyc_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    ffv_d      = ffv_q;
    ffa_d      = ffa_q;
    to_d       = to_q;
    idx_d      = '0;
    cmp_vld_d  = 1'b0;
    cmp_addr_d = cmp_addr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_MONITOR;
          run_d   = '0;
          last_d  = '0;
          cyc_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffa_d   = '0;
          to_d    = 1'b0;
        end
      end

      S_MONITOR: begin
        cyc_d = cyc_q + 1'b1;
        if (inst == last_q) begin
          if (run_q != RUN_MAX) run_d = run_q + 1'b1;
        end else begin
          run_d  = '0;
          last_d = inst;
        end
        // The run trigger has priority so a coincident timeout does not flag timed_out.
        if (run_d == RUN_MAX) begin
          state_d = S_SWEEP;
        end else if (timeout_hit) begin
          state_d = S_SWEEP;
          to_d    = 1'b1;
        end
      end

      S_SWEEP: begin
        if (issue) idx_d = idx_q + 1'b1;
        cmp_vld_d  = issue;
        cmp_addr_d = addr_now;
        if (cmp_vld_q) begin
          if (con_out == exp_data) begin
            pass_d = pass_q + 1'b1;
          end else begin
            fail_d = fail_q + 1'b1;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffa_d = cmp_addr_q;
            end
          end
        end
        // With every address issued, this cycle holds the trailing compare.
        if (!issue) state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign con_addr         = addr_now;
  assign exp_addr         = addr_now;
  assign con_rd           = issue;
  assign busy             = (state_q == S_MONITOR) || (state_q == S_SWEEP);
  assign done             = (state_q == S_DONE);
  assign timed_out        = to_q;
  assign cycle_count      = cyc_q;
  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_addr  = ffa_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_result_checker.sv
// Bench for mem_result_checker: two instances (plain window and an address-wrapping window)
// checked every cycle against a phase-level model plus literal expectations.
module tb_mem_result_checker;

  localparam int RUN_LEN = 10;
  localparam int MAXC    = 50;

  typedef struct packed {
    logic [31:0] pass;
    logic [31:0] fail;
    logic        v;
    logic [9:0]  a;
  } res_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] inst = 32'h0;
  always #5 clk = ~clk;

  logic [31:0] core_mem [1024];
  logic [31:0] exp_mem  [1024];

  logic [1:0]  o_busy, o_done, o_to, o_rd, o_ffv;
  logic [9:0]  o_con_addr [2];
  logic [9:0]  o_exp_addr [2];
  logic [9:0]  o_ffa [2];
  logic [31:0] o_cyc [2];
  logic [31:0] o_pass [2];
  logic [31:0] o_fail [2];
  logic [31:0] con_out_r [2];
  logic [31:0] exp_data_r [2];
  logic [1:0]  dbg_a, dbg_b;

  int total = 0;
  int bad = 0;

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      con_out_r[u]  <= core_mem[o_con_addr[u]];
      exp_data_r[u] <= exp_mem[o_exp_addr[u]];
    end
  end

  mem_result_checker #(.DATA_W(32), .ADDR_W(10), .BASE(0), .DEPTH(100), .RUN_LEN(RUN_LEN),
                       .CNT_W(32), .MAX_CYCLES(MAXC)) dut_a (
    .CLK(clk), .rst(rst), .start(start), .inst(inst),
    .con_addr(o_con_addr[0]), .con_rd(o_rd[0]), .con_out(con_out_r[0]),
    .exp_addr(o_exp_addr[0]), .exp_data(exp_data_r[0]),
    .busy(o_busy[0]), .done(o_done[0]), .timed_out(o_to[0]), .cycle_count(o_cyc[0]),
    .pass_count(o_pass[0]), .fail_count(o_fail[0]),
    .first_fail_valid(o_ffv[0]), .first_fail_addr(o_ffa[0]), .dbg_state(dbg_a)
  );

  mem_result_checker #(.DATA_W(32), .ADDR_W(10), .BASE(1020), .DEPTH(6), .RUN_LEN(RUN_LEN),
                       .CNT_W(32), .MAX_CYCLES(MAXC)) dut_b (
    .CLK(clk), .rst(rst), .start(start), .inst(inst),
    .con_addr(o_con_addr[1]), .con_rd(o_rd[1]), .con_out(con_out_r[1]),
    .exp_addr(o_exp_addr[1]), .exp_data(exp_data_r[1]),
    .busy(o_busy[1]), .done(o_done[1]), .timed_out(o_to[1]), .cycle_count(o_cyc[1]),
    .pass_count(o_pass[1]), .fail_count(o_fail[1]),
    .first_fail_valid(o_ffv[1]), .first_fail_addr(o_ffa[1]), .dbg_state(dbg_b)
  );

  function automatic int base_of(int u);
    return (u == 0) ? 0 : 1020;
  endfunction

  function automatic int depth_of(int u);
    return (u == 0) ? 100 : 6;
  endfunction

  function automatic int next_run(int r, bit same);
    if (!same) return 0;
    return (r >= RUN_LEN) ? RUN_LEN : r + 1;
  endfunction

  // Expected sweep outcome straight from the two memory images.
  function automatic res_t calc(int base, int depth);
    res_t r;
    r = '0;
    for (int i = 0; i < depth; i++) begin
      int ad;
      ad = (base + i) % 1024;
      if (core_mem[ad] == exp_mem[ad]) begin
        r.pass = r.pass + 32'd1;
      end else begin
        r.fail = r.fail + 32'd1;
        if (!r.v) begin
          r.v = 1'b1;
          r.a = ad[9:0];
        end
      end
    end
    return r;
  endfunction

  // model: phase 0 idle, 1 monitor, 2 sweep (k = cycle within sweep), 3 done
  int          m_ph [2];
  int          m_run [2];
  int          m_k [2];
  logic [31:0] m_last [2];
  logic [31:0] m_cyc [2];
  logic        m_to [2];
  res_t        m_res [2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_ph[u]   <= 0;
        m_run[u]  <= 0;
        m_k[u]    <= 0;
        m_last[u] <= 32'h0;
        m_cyc[u]  <= 32'h0;
        m_to[u]   <= 1'b0;
        m_res[u]  <= '0;
      end else begin
        case (m_ph[u])
          0, 3: if (start) begin
            m_ph[u]   <= 1;
            m_run[u]  <= 0;
            m_last[u] <= 32'h0;
            m_cyc[u]  <= 32'h0;
            m_to[u]   <= 1'b0;
          end
          1: begin
            m_cyc[u] <= m_cyc[u] + 32'd1;
            m_run[u] <= next_run(m_run[u], inst == m_last[u]);
            if (inst != m_last[u]) m_last[u] <= inst;
            if (next_run(m_run[u], inst == m_last[u]) == RUN_LEN) begin
              m_ph[u]  <= 2;
              m_k[u]   <= 0;
              m_res[u] <= calc(base_of(u), depth_of(u));
            end
`ifdef CHECKER_TIMEOUT_EN
            else if (m_cyc[u] + 32'd1 == 32'(MAXC)) begin
              m_ph[u]  <= 2;
              m_k[u]   <= 0;
              m_to[u]  <= 1'b1;
              m_res[u] <= calc(base_of(u), depth_of(u));
            end
`endif
          end
          2: begin
            m_k[u] <= m_k[u] + 1;
            if (m_k[u] == depth_of(u)) m_ph[u] <= 3;
          end
          default: ;
        endcase
      end
    end
  end

  // scoreboard check
  task automatic chk(input string name, input int u, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s[%0d] got=%0h want=%0h", name, u, act, exp);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk("busy", u, 64'(o_busy[u]), 64'(m_ph[u] == 1 || m_ph[u] == 2));
      chk("done", u, 64'(o_done[u]), 64'(m_ph[u] == 3));
      chk("con_rd", u, 64'(o_rd[u]), 64'(m_ph[u] == 2 && m_k[u] < depth_of(u)));
      chk("timed_out", u, 64'(o_to[u]), 64'(m_to[u]));
      chk("cycle_count", u, 64'(o_cyc[u]), 64'(m_cyc[u]));
      if (m_ph[u] == 2 && m_k[u] < depth_of(u)) begin
        chk("con_addr", u, 64'(o_con_addr[u]), 64'((base_of(u) + m_k[u]) % 1024));
        chk("exp_addr", u, 64'(o_exp_addr[u]), 64'((base_of(u) + m_k[u]) % 1024));
      end
      if (m_ph[u] == 0) begin
        chk("idle_con_addr", u, 64'(o_con_addr[u]), 64'(base_of(u)));
        chk("idle_ffa", u, 64'(o_ffa[u]), 64'(0));
      end
      if (m_ph[u] <= 1) begin
        chk("pass_clr", u, 64'(o_pass[u]), 64'(0));
        chk("fail_clr", u, 64'(o_fail[u]), 64'(0));
        chk("ffv_clr", u, 64'(o_ffv[u]), 64'(0));
      end
      if (m_ph[u] == 3) begin
        chk("pass_count", u, 64'(o_pass[u]), 64'(m_res[u].pass));
        chk("fail_count", u, 64'(o_fail[u]), 64'(m_res[u].fail));
        chk("ffv", u, 64'(o_ffv[u]), 64'(m_res[u].v));
        if (m_res[u].v) chk("ffa", u, 64'(o_ffa[u]), 64'(m_res[u].a));
      end
    end
  end

  // driver tasks
  function automatic logic [31:0] stream_val(int mode, int j, logic [31:0] prev);
    case (mode)
      0: return (j == 2) ? 32'h0010_0093 : 32'h0000_0013;
      1: return prev + 32'd1;
      default: return ($urandom_range(0, 3) == 0) ? $urandom : prev;
    endcase
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) begin
      core_mem[i] = $urandom;
      exp_mem[i]  = core_mem[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_done(input int mode, input int budget, output int first_j,
                             output int done_j, output int rd_a, output int rd_b);
    first_j = -1;
    done_j  = -1;
    rd_a    = 0;
    rd_b    = 0;
    @(negedge clk);
    start = 1'b1;
    inst  = stream_val(mode, 0, inst);
    for (int j = 1; j <= budget; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_rd[0]) begin
        rd_a++;
        if (first_j < 0) first_j = j;
      end
      if (o_rd[1]) rd_b++;
      if (o_done[0] && done_j < 0) done_j = j;
      if (o_done == 2'b11) break;
      inst = stream_val(mode, j, inst);
    end
    chk("wait_done", 0, 64'(o_done), 64'(2'b11));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=stuck want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fj, dj, ra, rb;
    fill_mem();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, 64'(o_busy), 64'(0));
    chk("rst_done", 0, 64'(o_done), 64'(0));
    chk("rst_con_addr", 1, 64'(o_con_addr[1]), 64'(1020));
    chk("rst_pass", 0, 64'(o_pass[0]), 64'(0));
    rst = 1'b0;

    // identical memories
    run_to_done(0, 400, fj, dj, ra, rb);
    chk("first_sweep_cycle", 0, 64'(fj), 64'(14));
    chk("sweep_len", 0, 64'(dj - fj), 64'(101));
    chk("rd_cycles", 0, 64'(ra), 64'(100));
    chk("rd_cycles", 1, 64'(rb), 64'(6));
    chk("cycle_lit", 0, 64'(o_cyc[0]), 64'(13));
    chk("pass_lit", 0, 64'(o_pass[0]), 64'(100));
    chk("fail_lit", 0, 64'(o_fail[0]), 64'(0));
    chk("ffv_lit", 0, 64'(o_ffv[0]), 64'(0));
    chk("pass_lit", 1, 64'(o_pass[1]), 64'(6));

    // mismatches at 17 and 42
    core_mem[17] = core_mem[17] ^ 32'h0000_0001;
    core_mem[42] = core_mem[42] ^ 32'h8000_0000;
    run_to_done(0, 400, fj, dj, ra, rb);
    chk("fail_lit", 0, 64'(o_fail[0]), 64'(2));
    chk("pass_lit", 0, 64'(o_pass[0]), 64'(98));
    chk("ffa_lit", 0, 64'(o_ffa[0]), 64'(17));
    chk("ffv_lit", 0, 64'(o_ffv[0]), 64'(1));
    chk("fail_lit", 1, 64'(o_fail[1]), 64'(0));

    // never-repeating stream
`ifdef CHECKER_TIMEOUT_EN
    run_to_done(1, 400, fj, dj, ra, rb);
    chk("to_lit", 0, 64'(o_to), 64'(2'b11));
    chk("cycle_to_lit", 0, 64'(o_cyc[0]), 64'(50));
    chk("cycle_to_lit", 1, 64'(o_cyc[1]), 64'(50));
    chk("sum_lit", 0, 64'(o_pass[0] + o_fail[0]), 64'(100));
`else
    @(negedge clk);
    start = 1'b1;
    for (int j = 1; j <= 1000; j++) begin
      @(negedge clk);
      start = (j == 500);
      inst  = inst + 32'd1;
    end
    start = 1'b0;
    chk("hang_busy", 0, 64'(o_busy), 64'(2'b11));
    chk("hang_done", 0, 64'(o_done), 64'(0));
    chk("hang_to", 0, 64'(o_to), 64'(0));
`endif

    // reset mid-sweep, then a fresh run with wrapped-address mismatches
    do_reset();
    fill_mem();
    core_mem[0]    = ~core_mem[0];
    core_mem[1022] = core_mem[1022] ^ 32'h0001_0000;
    @(negedge clk);
    start = 1'b1;
    inst  = stream_val(0, 0, inst);
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_rd[0] && o_con_addr[0] == 10'd60) break;
      inst = stream_val(0, j, inst);
    end
    chk("reach_addr60", 0, 64'(o_con_addr[0]), 64'(60));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 0, 64'(o_busy[0]), 64'(0));
    chk("abort_rd", 0, 64'(o_rd[0]), 64'(0));
    chk("abort_pass", 0, 64'(o_pass[0]), 64'(0));
    chk("abort_fail", 0, 64'(o_fail[0]), 64'(0));
    chk("abort_cycle", 0, 64'(o_cyc[0]), 64'(0));
    chk("abort_done", 1, 64'(o_done[1]), 64'(0));
    rst = 1'b0;
    run_to_done(0, 400, fj, dj, ra, rb);
    chk("sum_lit", 0, 64'(o_pass[0] + o_fail[0]), 64'(100));
    chk("fail_lit", 0, 64'(o_fail[0]), 64'(1));
    chk("ffa_lit", 0, 64'(o_ffa[0]), 64'(0));
    chk("pass_lit", 1, 64'(o_pass[1]), 64'(4));
    chk("fail_lit", 1, 64'(o_fail[1]), 64'(2));
    chk("ffa_lit", 1, 64'(o_ffa[1]), 64'(1022));

    // random images and random instruction streams
    for (int r = 0; r < 6; r++) begin
      int nflip;
      fill_mem();
      nflip = $urandom_range(0, 5);
      for (int f = 0; f < nflip; f++) begin
        int ad;
        ad = (r % 2 == 0) ? $urandom_range(0, 99) : $urandom_range(1018, 1023);
        core_mem[ad] = core_mem[ad] ^ (32'h1 << $urandom_range(0, 31));
      end
      run_to_done(2, 3000, fj, dj, ra, rb);
      chk("rand_rd_cycles", 0, 64'(ra), 64'(100));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
